// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - microword field map, sequencer opcodes and FSM states
package microseq_pkg;

  localparam int UWORD_W   = 40;

  localparam int SEQ_MSB   = 39;
  localparam int SEQ_LSB   = 37;
  localparam int ADDR_MSB  = 36;
  localparam int ADDR_LSB  = 31;
  localparam int ASEL_MSB  = 30;
  localparam int ASEL_LSB  = 28;
  localparam int BSEL_MSB  = 27;
  localparam int BSEL_LSB  = 25;
  localparam int DSEL_MSB  = 24;
  localparam int DSEL_LSB  = 22;
  localparam int ALUOP_MSB = 21;
  localparam int ALUOP_LSB = 19;
  localparam int RSVD_MSB  = 18;
  localparam int RSVD_LSB  = 16;
  localparam int RIN_MSB   = 15;
  localparam int RIN_LSB   = 0;

  localparam logic [2:0] SEQ_NEXT = 3'd0;
  localparam logic [2:0] SEQ_JMP  = 3'd1;
  localparam logic [2:0] SEQ_JZ   = 3'd2;
  localparam logic [2:0] SEQ_JN   = 3'd3;
  localparam logic [2:0] SEQ_CALL = 3'd4;
  localparam logic [2:0] SEQ_RET  = 3'd5;
  localparam logic [2:0] SEQ_HALT = 3'd6;
  localparam logic [2:0] SEQ_ILL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/useq_stack.sv
// rtl/useq_stack.sv - small LIFO holding micro-call return addresses
module useq_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [2**AW];
  logic [AW:0]   sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (sp == (AW+1)'(DEPTH));
  assign empty  = (sp == '0);
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read below the stack pointer.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/microseq_ctrl.sv
// rtl/microseq_ctrl.sv - micro-program sequencer: uPC, next-address mux and run/halt FSM
module microseq_ctrl
  import microseq_pkg::*;
#(
  parameter logic [5:0] START_ADDR  = 6'd0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               COND_Z,
  input  logic               COND_N,
  output logic [5:0]         UADDR,
  input  logic [UWORD_W-1:0] UWORD,
  output logic [2:0]         ASEL,
  output logic [2:0]         BSEL,
  output logic [2:0]         DSEL,
  output logic [15:0]        RIN,
  output logic [2:0]         ALUOP,
  output logic               BUSY,
  output logic               HALTED,
  output logic               ERR
);

  state_t     state, state_n;
  logic [5:0] upc, upc_n, upc_inc, tgt, ret_addr;
  logic [2:0] seq;
  logic       err, err_n;
  logic       push, pop, clr, full, empty;
  logic       unused_rsvd;

  assign seq         = UWORD[SEQ_MSB:SEQ_LSB];
  assign tgt         = UWORD[ADDR_MSB:ADDR_LSB];
  assign upc_inc     = upc + 6'd1;
  assign unused_rsvd = ^UWORD[RSVD_MSB:RSVD_LSB];
  assign UADDR       = upc;
  assign ERR         = err;

  useq_stack #(.DEPTH(STACK_DEPTH), .W(6)) u_stack (
    .clk   (CLK),
    .rst   (RST),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .dout  (ret_addr),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      upc   <= START_ADDR;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      upc   <= upc_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    upc_n   = upc;
    err_n   = err;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_RUN: begin
        case (seq)
          SEQ_NEXT: upc_n = upc_inc;
          SEQ_JMP:  upc_n = tgt;
          SEQ_JZ:   upc_n = COND_Z ? tgt : upc_inc;
          SEQ_JN:   upc_n = COND_N ? tgt : upc_inc;
          SEQ_CALL: begin
            if (full) begin
              err_n   = 1'b1;
              state_n = ST_HALT;
            end else begin
              push  = 1'b1;
              upc_n = tgt;
            end
          end
          SEQ_RET: begin
            if (empty) begin
              err_n   = 1'b1;
              state_n = ST_HALT;
            end else begin
              pop   = 1'b1;
              upc_n = ret_addr;
            end
          end
          SEQ_HALT: state_n = ST_HALT;
          default: begin
            err_n   = 1'b1;
            state_n = ST_HALT;
          end
        endcase
      end
      default: begin
        if (START) begin
          state_n = ST_RUN;
          upc_n   = START_ADDR;
          err_n   = 1'b0;
          clr     = 1'b1;
        end
      end
    endcase
  end

  // Outside RUN every field is forced to zero so DSEL=0 suppresses register writes.
  always_comb begin
    ASEL   = '0;
    BSEL   = '0;
    DSEL   = '0;
    ALUOP  = '0;
    RIN    = '0;
    BUSY   = (state == ST_RUN);
    HALTED = (state == ST_HALT);
    if (state == ST_RUN) begin
      ASEL  = UWORD[ASEL_MSB:ASEL_LSB];
      BSEL  = UWORD[BSEL_MSB:BSEL_LSB];
      DSEL  = UWORD[DSEL_MSB:DSEL_LSB];
      ALUOP = UWORD[ALUOP_MSB:ALUOP_LSB];
      RIN   = UWORD[RIN_MSB:RIN_LSB];
    end
  end

endmodule

// File: tb/tb_microseq_ctrl.sv
// tb/tb_microseq_ctrl.sv - scoreboard bench for microseq_ctrl with a behavioural control store
module tb_microseq_ctrl;

  logic        CLK = 1'b0;
  logic        RST, START, COND_Z, COND_N;
  logic [5:0]  UADDR;
  logic [39:0] UWORD;
  logic [2:0]  ASEL, BSEL, DSEL, ALUOP;
  logic [15:0] RIN;
  logic        BUSY, HALTED, ERR;

  logic [39:0] rom [64];
  assign UWORD = rom[UADDR];

  microseq_ctrl #(.START_ADDR(6'd0), .STACK_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .COND_Z(COND_Z), .COND_N(COND_N),
    .UADDR(UADDR), .UWORD(UWORD), .ASEL(ASEL), .BSEL(BSEL), .DSEL(DSEL),
    .RIN(RIN), .ALUOP(ALUOP), .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       name;
    logic [5:0]  ua;
    logic        busy;
    logic        halted;
    logic        err;
    logic [27:0] flds;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: at each falling edge, compare every expectation due at this cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || UADDR !== e.ua || BUSY !== e.busy || HALTED !== e.halted ||
          ERR !== e.err || {ASEL, BSEL, DSEL, ALUOP, RIN} !== e.flds) begin
        errors++;
        $display("FAIL %s: got ua=%0d busy=%b halted=%b err=%b flds=%h, want ua=%0d busy=%b halted=%b err=%b flds=%h (due cyc %0d, now %0d)",
                 e.name, UADDR, BUSY, HALTED, ERR, {ASEL, BSEL, DSEL, ALUOP, RIN},
                 e.ua, e.busy, e.halted, e.err, e.flds, e.cyc, cyc);
      end
    end
  end

  function automatic logic [39:0] mw(logic [2:0] seq, logic [5:0] addr, logic [2:0] a,
                                     logic [2:0] b, logic [2:0] d, logic [2:0] op, logic [15:0] rin);
    return {seq, addr, a, b, d, op, 3'b000, rin};
  endfunction

  task automatic ex(int dc, string nm, logic [5:0] ua, logic b, logic h, logic er,
                    logic [27:0] f = 28'd0);
    exp_t x;
    x.cyc = cyc + dc; x.name = nm; x.ua = ua; x.busy = b; x.halted = h; x.err = er; x.flds = f;
    sb.push_back(x);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 64; i++) rom[i] = mw(3'd6, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
  endtask

  // Branch at uPC 2 to 10, falling through to 3; both targets halt.
  task automatic run_branch(string nm, logic [5:0] tgt);
    START = 1'b1;
    ex(3, nm, tgt, 1'b1, 1'b0, 1'b0);
    ex(4, {nm, "_halt"}, tgt, 1'b0, 1'b1, 1'b0);
    tick(1);
    START = 1'b0;
    tick(4);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; COND_Z = 1'b0; COND_N = 1'b0;
    clr_rom();
    tick(2);
    RST = 1'b0;
    ex(1, "reset", 6'd0, 1'b0, 1'b0, 1'b0);
    tick(2);

    // Start: NEXT with ASEL=3/RIN=AA, then HALT that still drives DSEL=5/ALUOP=2
    rom[0] = mw(3'd0, 6'd0, 3'd3, 3'd0, 3'd0, 3'd0, 16'h00AA);
    rom[1] = mw(3'd6, 6'd0, 3'd0, 3'd0, 3'd5, 3'd2, 16'h0);
    START = 1'b1;
    ex(1, "start_c1", 6'd0, 1'b1, 1'b0, 1'b0, {3'd3, 3'd0, 3'd0, 3'd0, 16'h00AA});
    ex(2, "start_c2", 6'd1, 1'b1, 1'b0, 1'b0, {3'd0, 3'd0, 3'd5, 3'd2, 16'h0000});
    ex(3, "halt_word", 6'd1, 1'b0, 1'b1, 1'b0);
    tick(1);
    START = 1'b0;
    tick(3);

    clr_rom();
    rom[0] = mw(3'd1, 6'd2, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[2] = mw(3'd2, 6'd10, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    COND_Z = 1'b1; run_branch("jz_taken", 6'd10);
    COND_Z = 1'b0; COND_N = 1'b1; run_branch("jz_not", 6'd3);
    rom[2] = mw(3'd3, 6'd10, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    run_branch("jn_taken", 6'd10);
    COND_Z = 1'b1; COND_N = 1'b0; run_branch("jn_not", 6'd3);
    COND_Z = 1'b0;

    // CALL 20 at 5, RET at 20 back to 6
    clr_rom();
    rom[0]  = mw(3'd1, 6'd5, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[5]  = mw(3'd4, 6'd20, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[20] = mw(3'd5, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(3, "call", 6'd20, 1'b1, 1'b0, 1'b0);
    ex(4, "ret", 6'd6, 1'b1, 1'b0, 1'b0);
    ex(5, "ret_halt", 6'd6, 1'b0, 1'b1, 1'b0);
    tick(1); START = 1'b0; tick(5);

    // Five nested CALLs overflow a 4-deep stack
    clr_rom();
    for (int i = 0; i < 5; i++) rom[i] = mw(3'd4, 6'(i + 1), 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(5, "ovf_fifth", 6'd4, 1'b1, 1'b0, 1'b0);
    ex(6, "ovf_err", 6'd4, 1'b0, 1'b1, 1'b1);
    tick(1); START = 1'b0; tick(6);
    START = 1'b1;
    ex(1, "ovf_restart", 6'd0, 1'b1, 1'b0, 1'b0);
    ex(6, "ovf_again", 6'd4, 1'b0, 1'b1, 1'b1);
    tick(1); START = 1'b0; tick(6);

    // NEXT at 63 wraps to 0
    clr_rom();
    rom[0]  = mw(3'd1, 6'd63, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[63] = mw(3'd0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(2, "at63", 6'd63, 1'b1, 1'b0, 1'b0);
    ex(3, "wrap", 6'd0, 1'b1, 1'b0, 1'b0);
    ex(4, "wrap_halt", 6'd0, 1'b0, 1'b1, 1'b0);
    tick(1); START = 1'b0; tick(1);
    rom[0] = mw(3'd6, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    tick(3);

    // RET on empty stack, then illegal opcode (its START also clears ERR)
    rom[0] = mw(3'd5, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(1, "ret_run", 6'd0, 1'b1, 1'b0, 1'b0);
    ex(2, "ret_empty", 6'd0, 1'b0, 1'b1, 1'b1);
    tick(1); START = 1'b0; tick(2);
    rom[0] = mw(3'd7, 6'd0, 3'd7, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(1, "ill_run", 6'd0, 1'b1, 1'b0, 1'b0, {3'd7, 25'd0});
    ex(2, "illegal", 6'd0, 1'b0, 1'b1, 1'b1);
    tick(1); START = 1'b0; tick(2);

    // START ignored in RUN, then async reset between edges at uPC 12
    clr_rom();
    rom[0] = mw(3'd1, 6'd10, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    for (int i = 10; i < 21; i++) rom[i] = mw(3'd0, 6'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    START = 1'b1;
    ex(2, "pre_rst", 6'd10, 1'b1, 1'b0, 1'b0);
    tick(1); START = 1'b0; tick(1);
    START = 1'b1;
    ex(1, "start_ign", 6'd11, 1'b1, 1'b0, 1'b0);
    tick(1); START = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    ex(0, "async_rst", 6'd0, 1'b0, 1'b0, 1'b0);
    tick(1);
    RST = 1'b0;
    ex(1, "post_rst", 6'd0, 1'b0, 1'b0, 1'b0);
    tick(3);

    if (sb.size() != 0) begin
      $display("FAIL flush: %0d expectations never checked, want 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/microseq_ctrl.md
# microseq_ctrl

Microprogram sequencer that sits directly upstream of the register file in the simple processor. It steps a micro-program counter (uPC) through an external 64-word control store and decodes each 40-bit microword into the register-file select fields (ASEL/BSEL/DSEL), the immediate (RIN) and an ALU opcode. Sequencing supports increment, unconditional and flag-conditional jumps, and call/return through a small hardware stack. One microinstruction executes per clock.

## Interface
- START_ADDR, 6'd0: uPC value loaded on reset and on START.
- STACK_DEPTH, 4: return-stack entries (1..8).

- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begins execution from START_ADDR.
- COND_Z  in  1  ALU zero flag, sampled at the rising edge that ends a JZ cycle.
- COND_N  in  1  ALU negative flag, sampled at the rising edge that ends a JN cycle.
- UADDR  out  6  control-store address (= uPC).
- UWORD  in  40  microword; combinational read of UADDR.
- ASEL, BSEL, DSEL  out  3 each  register-file selects.
- RIN  out  16  immediate to register file.
- ALUOP  out  3  ALU operation.
- BUSY  out  1  high in RUN.
- HALTED  out  1  high in HALT.
- ERR  out  1  sticky stack/opcode error.

## Operation
- Microword fields: [39:37] SEQ, [36:31] target ADDR, [30:28] ASEL, [27:25] BSEL, [24:22] DSEL, [21:19] ALUOP, [18:16] reserved (ignored), [15:0] RIN.
- SEQ encodings:
  - 0 NEXT: uPC+1.
  - 1 JMP: ADDR.
  - 2 JZ: ADDR if COND_Z, else uPC+1.
  - 3 JN: ADDR if COND_N, else uPC+1.
  - 4 CALL: push uPC+1, go to ADDR.
  - 5 RET: pop into uPC.
  - 6 HALT: enter HALT.
  - 7 illegal: set ERR, enter HALT.
- States:
  - IDLE: START -> RUN with uPC=START_ADDR, stack emptied, ERR cleared.
  - RUN: executes the microword at uPC each cycle.
  - HALT: HALT/illegal/error -> HALT. START -> RUN, with the same initialisation as from IDLE.
- In RUN, ASEL/BSEL/DSEL/RIN/ALUOP follow UWORD combinationally. In IDLE and HALT they are all zero, so DSEL=0 means no write.
- The microword executing HALT still drives its fields for that cycle.
- uPC+1 wraps 63 -> 0 without error.
- CALL with stack full: no push, ERR=1, go to HALT.
- RET with stack empty: ERR=1, go to HALT.
- START while in RUN is ignored.
- ERR stays at 1 until the next accepted START or RST.

## Timing
- Reset values: state IDLE, uPC=START_ADDR, UADDR=START_ADDR, stack pointer 0, ASEL/BSEL/DSEL/ALUOP=0, RIN=0, BUSY=0, HALTED=0, ERR=0.
- RST asserted mid-run forces the reset values immediately, without waiting for CLK.
- START sampled high at edge k: BUSY=1 and UADDR=START_ADDR from edge k onward. The first microword executes in cycle k..k+1.
- Next-address latency is one cycle: the SEQ decision made at edge n gives UADDR its new value after edge n.
- Branch flags and stack push/pop take effect at the same edge as the uPC update.
- HALT executing in cycle n: HALTED=1 and BUSY=0 after edge n.

## Structure
- Package microseq_pkg:
  - UWORD_W=40.
  - Field MSB/LSB constants.
  - SEQ opcode constants.
  - State encoding for IDLE/RUN/HALT.
- Sub-module useq_stack: parameterised LIFO.
  - Inputs: push, pop, din[5:0].
  - Outputs: dout[5:0], full, empty.
  - Asynchronous active-high reset.
- Top level holds the FSM, the uPC register and the next-address mux.

## Test plan
- Reset and start:
  - RST pulse gives UADDR=0, BUSY=0, all outputs 0.
  - START with ROM[0]=NEXT, ASEL=3, RIN=16'h00AA gives ASEL=3 and RIN=16'h00AA in cycle 1.
  - Next cycle UADDR=1.
- Conditional branch at uPC 2 (JZ ADDR=10):
  - COND_Z=1 -> UADDR=10.
  - Rerun with COND_Z=0 -> UADDR=3.
  - JN behaves the same way on COND_N.
- Call/return: CALL 20 at uPC 5 -> UADDR=20; RET at 20 -> UADDR=6; ERR=0.
- Stack overflow: five nested CALLs with STACK_DEPTH=4 -> ERR=1, HALTED=1, all outputs 0. A following START clears ERR.
- Edge cases:
  - NEXT at uPC 63 -> UADDR=0.
  - RET on empty stack -> ERR=1.
  - SEQ=7 -> ERR=1, HALTED=1.
- Async reset mid-RUN (uPC=12, between clock edges) -> UADDR=START_ADDR and BUSY=0 immediately. START mid-RUN changes nothing.
